// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types for the device bus arbiter: FSM state encoding and master indices.
package dev_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int M_CPU = 0;
  localparam int M_DMA = 1;

endpackage

// File: rtl/dev_bus_arbiter_rr_pick.sv
// Two-input round-robin chooser: on a tie, the master that did not own the bus last wins.
module dev_bus_arbiter_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) owner = ~last_owner;
    else              owner = req[1];
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master device bus arbiter with round-robin grant and one-transfer-at-a-time FSM.
// Optional watchdog on BUSY is enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; latches owner and its transfer on grant
// BUSY  | bus driven for owner until bus_ready (or watchdog expiry)
// DONE  | one-cycle completion pulse to owner
module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          m_req,
  input  logic [1:0]          m_we,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [2*DATA_W-1:0] m_wdata,
  output logic [1:0]          m_gnt,
  output logic [1:0]          m_done,
  output logic [1:0]          m_err,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_we,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready
);

  state_t state, state_nxt;
  logic   owner_q, last_owner_q, we_q, err_q;
  logic   pick_owner, pick_valid;
  logic   expire;

  dev_bus_arbiter_rr_pick u_rr_pick (
    .req        (m_req),
    .last_owner (last_owner_q),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;

  // Expiry is suppressed when ready arrives in the same cycle.
  assign expire = (state == BUSY) && !bus_ready && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)                  timer <= '0;
      else if (state == BUSY && !bus_ready) timer <= timer + TW'(1);
      if (expire)             err_q <= 1'b1;
      else if (state == DONE) err_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
  assign err_q  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (bus_ready || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      m_rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          owner_q   <= pick_owner;
          we_q      <= m_we[pick_owner];
          bus_addr  <= pick_owner ? m_addr[2*ADDR_W-1:ADDR_W]   : m_addr[ADDR_W-1:0];
          bus_wdata <= pick_owner ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
        end
        BUSY: begin
          if (bus_ready) begin
            if (!we_q) m_rdata <= bus_rdata;
          end else if (expire) begin
            m_rdata <= '0;
          end
        end
        DONE: last_owner_q <= owner_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_gnt  = 2'b00;
    m_done = 2'b00;
    m_err  = 2'b00;
    bus_we = 1'b0;
    if (state == BUSY) begin
      m_gnt[owner_q] = 1'b1;
      bus_we         = we_q;
    end
    if (state == DONE) begin
      m_done[owner_q] = 1'b1;
      m_err[owner_q]  = err_q;
    end
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed self-checking bench for dev_bus_arbiter; watchdog steps run only with ARB_TIMEOUT_EN.
module tb_dev_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  m_gnt, m_done, m_err;
  logic [31:0] m_rdata, bus_addr, bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  dev_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_gnt     (m_gnt),
    .m_done    (m_done),
    .m_err     (m_err),
    .m_rdata   (m_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_gnt",   {30'd0, m_gnt},  32'h0);
    chk("rst_done",  {30'd0, m_done}, 32'h0);
    chk("rst_err",   {30'd0, m_err},  32'h0);
    chk("rst_rdata", m_rdata,         32'h0);
    chk("rst_addr",  bus_addr,        32'h0);
    chk("rst_we",    {31'd0, bus_we}, 32'h0);
    rst = 1'b1;
    step();

    // simultaneous requests after reset: CPU first, then DMA
    m_addr = {32'h0000_0200, 32'h0000_0100};
    m_req = 2'b11;
    step();
    chk("tie1_gnt",  {30'd0, m_gnt}, 32'h1);
    chk("tie1_addr", bus_addr,       32'h100);
    bus_ready = 1'b1; bus_rdata = 32'hAAAA_0000;
    step();
    chk("tie1_done",  {30'd0, m_done}, 32'h1);
    chk("tie1_rdata", m_rdata,         32'hAAAA_0000);
    m_req = 2'b10; bus_ready = 1'b0;
    step();
    chk("tie1_idle_gnt", {30'd0, m_gnt}, 32'h0);
    step();
    chk("tie2_gnt",  {30'd0, m_gnt}, 32'h2);
    chk("tie2_addr", bus_addr,       32'h200);
    bus_ready = 1'b1; bus_rdata = 32'hBBBB_1111;
    step();
    chk("tie2_done",  {30'd0, m_done}, 32'h2);
    chk("tie2_rdata", m_rdata,         32'hBBBB_1111);
    m_req = 2'b00; bus_ready = 1'b0;
    step();
    m_req = 2'b11;
    step();
    chk("tie3_gnt", {30'd0, m_gnt}, 32'h1);
    bus_ready = 1'b1;
    step();
    chk("tie3_done", {30'd0, m_done}, 32'h1);
    m_req = 2'b10; bus_ready = 1'b0;
    step(); step();
    chk("tie4_gnt", {30'd0, m_gnt}, 32'h2);
    bus_ready = 1'b1;
    step();
    chk("tie4_done", {30'd0, m_done}, 32'h2);
    m_req = 2'b00; bus_ready = 1'b0;
    step();

    // CPU read, ready after 2 BUSY cycles
    m_addr = {32'h0, 32'h0000_7F00}; m_we = 2'b00; m_req = 2'b01;
    step();
    chk("rd_gnt_c1", {30'd0, m_gnt},  32'h1);
    chk("rd_addr",   bus_addr,        32'h7F00);
    chk("rd_we_c1",  {31'd0, bus_we}, 32'h0);
    step();
    chk("rd_gnt_c2", {30'd0, m_gnt},  32'h1);
    chk("rd_done_c2",{30'd0, m_done}, 32'h0);
    chk("rd_we_c2",  {31'd0, bus_we}, 32'h0);
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    chk("rd_done",  {30'd0, m_done}, 32'h1);
    chk("rd_gnt_d", {30'd0, m_gnt},  32'h0);
    chk("rd_rdata", m_rdata,         32'hDEAD_BEEF);
    chk("rd_err",   {30'd0, m_err},  32'h0);
    m_req = 2'b00; bus_ready = 1'b0;
    step();
    chk("rd_done_once", {30'd0, m_done}, 32'h0);

    // DMA write with immediate ready
    m_addr = {32'h0000_7F10, 32'h0}; m_wdata = {32'h1234_5678, 32'h0};
    m_we = 2'b10; m_req = 2'b10; bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    chk("wr_we",    {31'd0, bus_we}, 32'h1);
    chk("wr_addr",  bus_addr,        32'h7F10);
    chk("wr_wdata", bus_wdata,       32'h1234_5678);
    chk("wr_gnt",   {30'd0, m_gnt},  32'h2);
    step();
    chk("wr_we_off", {31'd0, bus_we}, 32'h0);
    chk("wr_done",   {30'd0, m_done}, 32'h2);
    chk("wr_rdata",  m_rdata,         32'hDEAD_BEEF);
    chk("wr_hold_addr", bus_addr,     32'h7F10);
    m_req = 2'b00; m_we = 2'b00; bus_ready = 1'b0;
    step();

    // request held through DONE: exactly one IDLE cycle between grants
    m_addr = {32'h0, 32'h0000_0040}; m_req = 2'b01; bus_ready = 1'b1; bus_rdata = 32'h0000_0040;
    step();
    chk("hold_gnt1", {30'd0, m_gnt}, 32'h1);
    step();
    chk("hold_done1", {30'd0, m_done}, 32'h1);
    step();
    chk("hold_gap_gnt",  {30'd0, m_gnt},  32'h0);
    chk("hold_gap_done", {30'd0, m_done}, 32'h0);
    step();
    chk("hold_gnt2", {30'd0, m_gnt}, 32'h1);
    step();
    chk("hold_done2", {30'd0, m_done}, 32'h1);
    m_req = 2'b00; bus_ready = 1'b0;
    step();

    // async reset mid-BUSY of a write
    m_addr = {32'h0, 32'h0000_7F20}; m_wdata = {32'h0, 32'hCAFE_0001};
    m_we = 2'b01; m_req = 2'b01;
    step();
    chk("mid_we_pre", {31'd0, bus_we}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("mid_we_rst",    {31'd0, bus_we}, 32'h0);
    chk("mid_gnt_rst",   {30'd0, m_gnt},  32'h0);
    chk("mid_addr_rst",  bus_addr,        32'h0);
    chk("mid_rdata_rst", m_rdata,         32'h0);
    m_req = 2'b00; m_we = 2'b00;
    step();
    rst = 1'b1;
    step();
    chk("mid_no_done1", {30'd0, m_done}, 32'h0);
    step();
    chk("mid_no_done2", {30'd0, m_done}, 32'h0);
    m_addr = {32'h0, 32'h0000_0010}; m_req = 2'b01; bus_ready = 1'b1; bus_rdata = 32'h0000_0055;
    step();
    chk("post_gnt", {30'd0, m_gnt}, 32'h1);
    step();
    chk("post_done",  {30'd0, m_done}, 32'h1);
    chk("post_rdata", m_rdata,         32'h55);
    m_req = 2'b00; bus_ready = 1'b0;
    step();

`ifdef ARB_TIMEOUT_EN
    // watchdog expiry after 15 BUSY cycles without ready
    m_addr = {32'h0000_0300, 32'h0}; m_req = 2'b10;
    step();
    repeat (14) step();
    chk("to_gnt_c15", {30'd0, m_gnt},  32'h2);
    chk("to_done_c15",{30'd0, m_done}, 32'h0);
    step();
    chk("to_done",  {30'd0, m_done}, 32'h2);
    chk("to_err",   {30'd0, m_err},  32'h2);
    chk("to_rdata", m_rdata,         32'h0);
    m_req = 2'b00;
    step();
    chk("to_err_off", {30'd0, m_err}, 32'h0);

    // ready on the 15th BUSY cycle wins over expiry
    m_req = 2'b10;
    step();
    repeat (14) step();
    chk("tr_gnt_c15", {30'd0, m_gnt}, 32'h2);
    bus_ready = 1'b1; bus_rdata = 32'h0000_0077;
    step();
    chk("tr_done",  {30'd0, m_done}, 32'h2);
    chk("tr_err",   {30'd0, m_err},  32'h0);
    chk("tr_rdata", m_rdata,         32'h77);
    m_req = 2'b00; bus_ready = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
